// File: rtl/cdb_broadcaster.sv
// Common data bus transmitter: buffers completed FU results per source and
// broadcasts at most one tagged result per cycle using round-robin arbitration.
module cdb_broadcaster #(
    parameter int NUM_SRC = 4,
    parameter int TAG_W   = 8,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*TAG_W-1:0]      src_tag,
    input  logic [NUM_SRC*DATA_W-1:0]     src_data,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic [TAG_W+DATA_W:0]         cdb,
    output logic [$clog2(NUM_SRC)-1:0]    cdb_src,
    output logic                          err_tag0,
    output logic                          busy
);

    localparam int IW = $clog2(NUM_SRC);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] nonEmpty;
    logic [NUM_SRC-1:0] tagZero;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [TAG_W-1:0]   headTag  [NUM_SRC];
    logic [DATA_W-1:0]  headData [NUM_SRC];

    logic               grantValid;
    logic [IW-1:0]      grantIdx;

    logic [IW-1:0]      rrPtr_q, rrPtr_d;
    logic               cdbOn_q, cdbOn_d;
    logic [TAG_W-1:0]   cdbTag_q, cdbTag_d;
    logic [DATA_W-1:0]  cdbData_q, cdbData_d;
    logic [IW-1:0]      cdbSrc_q, cdbSrc_d;
    logic               errTag0_q, errTag0_d;

    // One small circular FIFO per source. A tag-0 result completes the
    // handshake but is never stored, and flush empties every FIFO at once.
    for (genvar g = 0; g < NUM_SRC; g++) begin : gSrc
        logic [PW-1:0]     wrPtr_q, wrPtr_d;
        logic [PW-1:0]     rdPtr_q, rdPtr_d;
        logic [CW-1:0]     count_q, count_d;
        logic [TAG_W-1:0]  tagMem_q  [DEPTH];
        logic [DATA_W-1:0] dataMem_q [DEPTH];
        logic [TAG_W-1:0]  offTag;

        assign offTag      = src_tag[g*TAG_W +: TAG_W];
        assign full[g]     = (count_q == CW'(DEPTH));
        assign nonEmpty[g] = (count_q != '0);
        assign tagZero[g]  = (offTag == '0);
        assign push[g]     = src_valid[g] & ~full[g] & ~tagZero[g] & ~flush;
        assign pop[g]      = grantValid & (grantIdx == IW'(g));
        assign headTag[g]  = tagMem_q[rdPtr_q];
        assign headData[g] = dataMem_q[rdPtr_q];

        // Advance FIFO pointers and occupancy for this cycle's push/pop.
        always_comb begin
            wrPtr_d = wrPtr_q;
            rdPtr_d = rdPtr_q;
            count_d = count_q;
            if (flush) begin
                wrPtr_d = '0;
                rdPtr_d = '0;
                count_d = '0;
            end else begin
                if (push[g]) wrPtr_d = wrPtr_q + PW'(1);
                if (pop[g])  rdPtr_d = rdPtr_q + PW'(1);
                if (push[g] && !pop[g])      count_d = count_q + CW'(1);
                else if (pop[g] && !push[g]) count_d = count_q - CW'(1);
            end
        end

        // FIFO control registers, cleared to empty on reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wrPtr_q <= '0;
                rdPtr_q <= '0;
                count_q <= '0;
            end else begin
                wrPtr_q <= wrPtr_d;
                rdPtr_q <= rdPtr_d;
                count_q <= count_d;
            end
        end

        // Storage array; contents only matter where occupancy says so.
        always_ff @(posedge clk) begin
            if (push[g]) begin
                tagMem_q[wrPtr_q]  <= offTag;
                dataMem_q[wrPtr_q] <= src_data[g*DATA_W +: DATA_W];
            end
        end
    end

    // Round-robin search: first non-empty source strictly after the pointer.
    always_comb begin
        logic [IW-1:0] candidate;
        grantValid = 1'b0;
        grantIdx   = '0;
        candidate  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            candidate = IW'((int'(rrPtr_q) + k) % NUM_SRC);
            if (!grantValid && nonEmpty[candidate]) begin
                grantValid = 1'b1;
                grantIdx   = candidate;
            end
        end
        if (flush) grantValid = 1'b0;
    end

    // Next broadcast, pointer update and sticky tag-0 error.
    always_comb begin
        rrPtr_d   = rrPtr_q;
        cdbOn_d   = 1'b0;
        cdbTag_d  = '0;
        cdbData_d = '0;
        cdbSrc_d  = cdbSrc_q;
        errTag0_d = errTag0_q | (|(src_valid & ~full & tagZero));
        if (grantValid) begin
            rrPtr_d   = grantIdx;
            cdbOn_d   = 1'b1;
            cdbTag_d  = headTag[grantIdx];
            cdbData_d = headData[grantIdx];
            cdbSrc_d  = grantIdx;
        end
    end

    // Registered CDB output and arbitration state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrPtr_q   <= IW'(NUM_SRC - 1);
            cdbOn_q   <= 1'b0;
            cdbTag_q  <= '0;
            cdbData_q <= '0;
            cdbSrc_q  <= '0;
            errTag0_q <= 1'b0;
        end else begin
            rrPtr_q   <= rrPtr_d;
            cdbOn_q   <= cdbOn_d;
            cdbTag_q  <= cdbTag_d;
            cdbData_q <= cdbData_d;
            cdbSrc_q  <= cdbSrc_d;
            errTag0_q <= errTag0_d;
        end
    end

    assign src_ready = ~full;
    assign cdb       = {cdbOn_q, cdbTag_q, cdbData_q};
    assign cdb_src   = cdbSrc_q;
    assign err_tag0  = errTag0_q;
    assign busy      = (|nonEmpty) | cdbOn_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Testbench for cdb_broadcaster: directed offers feed an expected-broadcast
// queue; a negedge monitor matches every CDB broadcast against it.
module tb_cdb_broadcaster;

    localparam int NUM_SRC = 4;
    localparam int TAG_W   = 8;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 2;
    localparam int ON_BIT  = TAG_W + DATA_W;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      flush;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*TAG_W-1:0]  src_tag;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_ready;
    logic [TAG_W+DATA_W:0]     cdb;
    logic [1:0]                cdb_src;
    logic                      err_tag0;
    logic                      busy;

    cdb_broadcaster #(.NUM_SRC(NUM_SRC), .TAG_W(TAG_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .src_valid(src_valid), .src_tag(src_tag), .src_data(src_data),
        .src_ready(src_ready), .cdb(cdb), .cdb_src(cdb_src),
        .err_tag0(err_tag0), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int               src;
        logic [TAG_W-1:0] tag;
        logic [DATA_W-1:0] data;
        int               cyc;
    } exp_t;
    exp_t expQ[$];

    bit gapCheck = 1'b0;
    bit seenSrc0 = 1'b0;
    int gap = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setSrc(input int s, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        src_valid[s] = 1'b1;
        src_tag[s*TAG_W +: TAG_W] = t;
        src_data[s*DATA_W +: DATA_W] = d;
    endtask

    task automatic expectB(input int s, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d, input int c);
        exp_t e;
        e.src = s; e.tag = t; e.data = d; e.cyc = c;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus();
        step();
        src_valid = '0;
        src_tag   = '0;
        src_data  = '0;
    endtask

    task automatic doReset();
        src_valid = '0;
        src_tag   = '0;
        src_data  = '0;
        flush     = 1'b0;
        rst       = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Monitor: every broadcast must match the oldest pending entry of its source.
    always @(negedge clk) begin
        if (!rst && cdb[ON_BIT]) begin : mon
            int idx;
            exp_t e;
            idx = -1;
            for (int k = 0; k < expQ.size(); k++)
                if (idx < 0 && expQ[k].src == int'(cdb_src)) idx = k;
            if (idx < 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected broadcast: src %0d tag %0h data %0h, expected none (cycle %0d)",
                         cdb_src, cdb[ON_BIT-1 -: TAG_W], cdb[DATA_W-1:0], cyc);
            end else begin
                e = expQ[idx];
                expQ.delete(idx);
                checkOutput("bcast tag", 64'(cdb[ON_BIT-1 -: TAG_W]), 64'(e.tag));
                checkOutput("bcast data", 64'(cdb[DATA_W-1:0]), 64'(e.data));
                if (e.cyc >= 0) checkOutput("bcast cycle", 64'(cyc), 64'(e.cyc));
                if (gapCheck) begin
                    if (cdb_src == 2'd0) begin
                        if (seenSrc0) checkOutput("src0 gap within NUM_SRC-1", 64'(gap <= NUM_SRC - 1), 64'd1);
                        seenSrc0 = 1'b1;
                        gap = 0;
                    end else if (seenSrc0) begin
                        gap++;
                    end
                end
            end
        end
    end

    initial begin
        int n0;
        int nS [NUM_SRC];
        bit lowSeen;
        logic [NUM_SRC-1:0] rdy;
        int e0;

        doReset();

        // Reset state
        checkOutput("reset cdb", 64'(cdb), 64'd0);
        checkOutput("reset cdb_src", 64'(cdb_src), 64'd0);
        checkOutput("reset err_tag0", 64'(err_tag0), 64'd0);
        checkOutput("reset src_ready", 64'(src_ready), 64'hF);
        checkOutput("reset busy", 64'(busy), 64'd0);

        // Single result, one-cycle latency, on for exactly one cycle
        setSrc(1, 8'h05, 32'hDEADBEEF);
        expectB(1, 8'h05, 32'hDEADBEEF, cyc + 2);
        applyStimulus();
        checkOutput("no same-cycle bypass", 64'(cdb[ON_BIT]), 64'd0);
        checkOutput("busy with queued result", 64'(busy), 64'd1);
        step();
        checkOutput("single cdb_src", 64'(cdb_src), 64'd1);
        step();
        checkOutput("cdb off after one cycle", 64'(cdb[ON_BIT]), 64'd0);
        checkOutput("idle busy", 64'(busy), 64'd0);

        // Contention fairness: two rounds of four simultaneous results
        doReset();
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                setSrc(s, 8'(s + 1), 32'h100 + 32'(s) + 32'(r * 16));
                expectB(s, 8'(s + 1), 32'h100 + 32'(s) + 32'(r * 16), cyc + 2 + s);
            end
            applyStimulus();
            repeat (5) step();
        end

        // Backpressure on source 0 while sources 1-3 stream
        doReset();
        gapCheck = 1'b1;
        seenSrc0 = 1'b0;
        gap = 0;
        n0 = 0;
        lowSeen = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) nS[s] = 0;
        for (int c = 0; c < 30; c++) begin
            src_valid = '0;
            if (n0 < 4) setSrc(0, 8'(10 + n0), 32'hB000_0000 + 32'(n0));
            if (c < 16)
                for (int s = 1; s < NUM_SRC; s++)
                    setSrc(s, 8'(16 * s + nS[s]), 32'hC000_0000 + 32'(16 * s + nS[s]));
            rdy = src_ready;
            if (n0 < 4 && !rdy[0]) lowSeen = 1'b1;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (src_valid[s] && rdy[s]) begin
                    expectB(s, src_tag[s*TAG_W +: TAG_W], src_data[s*DATA_W +: DATA_W], -1);
                    if (s == 0) n0++;
                    else nS[s]++;
                end
            end
            step();
        end
        src_valid = '0;
        repeat (40) step();
        gapCheck = 1'b0;
        checkOutput("src0 all four accepted", 64'(n0), 64'd4);
        checkOutput("src0 ready dropped", 64'(lowSeen), 64'd1);
        checkOutput("backpressure drained", 64'(expQ.size()), 64'd0);

        // Tag-0 results are dropped and flagged
        doReset();
        setSrc(2, 8'h00, 32'd7);
        applyStimulus();
        checkOutput("err_tag0 set", 64'(err_tag0), 64'd1);
        checkOutput("tag0 not queued", 64'(busy), 64'd0);
        repeat (3) step();
        checkOutput("err_tag0 held", 64'(err_tag0), 64'd1);
        setSrc(2, 8'h09, 32'h99);
        expectB(2, 8'h09, 32'h99, cyc + 2);
        applyStimulus();
        repeat (3) step();
        checkOutput("err_tag0 still held", 64'(err_tag0), 64'd1);

        // Flush drops buffered and in-flight offers, keeps the pointer
        doReset();
        e0 = cyc;
        setSrc(0, 8'h21, 32'h2121);
        setSrc(3, 8'h31, 32'h3131);
        expectB(0, 8'h21, 32'h2121, e0 + 2);
        applyStimulus();
        setSrc(0, 8'h22, 32'h2222);
        setSrc(3, 8'h32, 32'h3232);
        applyStimulus();
        flush = 1'b1;
        setSrc(1, 8'h06, 32'h0606);
        checkOutput("bcast visible in flush cycle", 64'(cdb[ON_BIT]), 64'd1);
        applyStimulus();
        flush = 1'b0;
        checkOutput("flush cdb off", 64'(cdb[ON_BIT]), 64'd0);
        checkOutput("flush busy", 64'(busy), 64'd0);
        checkOutput("flush src_ready", 64'(src_ready), 64'hF);
        repeat (3) step();
        setSrc(0, 8'h61, 32'h6161);
        setSrc(1, 8'h62, 32'h6262);
        expectB(1, 8'h62, 32'h6262, cyc + 2);
        expectB(0, 8'h61, 32'h6161, cyc + 3);
        applyStimulus();
        repeat (4) step();

        // Asynchronous reset while a broadcast is on the bus
        doReset();
        setSrc(2, 8'h00, 32'd1);
        applyStimulus();
        setSrc(1, 8'h41, 32'h4141);
        expectB(1, 8'h41, 32'h4141, cyc + 2);
        applyStimulus();
        step();
        checkOutput("cdb on before reset", 64'(cdb[ON_BIT]), 64'd1);
        #6;
        rst = 1'b1;
        #1;
        checkOutput("async reset cdb", 64'(cdb), 64'd0);
        checkOutput("async reset err_tag0", 64'(err_tag0), 64'd0);
        step();
        rst = 1'b0;
        setSrc(0, 8'h50, 32'h5050);
        setSrc(2, 8'h52, 32'h5252);
        expectB(0, 8'h50, 32'h5050, cyc + 2);
        expectB(2, 8'h52, 32'h5252, cyc + 3);
        applyStimulus();
        repeat (4) step();

        checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
